// File: rtl/f_max_unpool_pkg.sv
// Shared constants for the float max-pool / max-unpool datapath units.
// Float zero fill and default field widths.
package f_max_unpool_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int DELAY_W_DEF = 7;

  // +0.0 in IEEE-754; sized down at the point of use.
  localparam logic [63:0] F_ZERO = 64'h0;

endpackage

// File: rtl/f_unpool_phase.sv
// Delay/stride phase counter: counts down from delay0 after run,
// then reloads strideMinusOne; start is high when it reaches zero.
module f_unpool_phase
  import f_max_unpool_pkg::*;
#(
  parameter int DELAY_W = DELAY_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [DELAY_W-1:0] strideMinusOne,
  input  logic [DELAY_W-1:0] delay0,
  output logic               start
);

  logic [DELAY_W-1:0] delay;

  // Free-running phase count, independent of the advance enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      delay <= '0;
    else if (run)
      delay <= delay0;
    else if (delay != '0)
      delay <= delay - DELAY_W'(1);
    else
      delay <= strideMinusOne;
  end

  assign start = (delay == '0);

endmodule

// File: rtl/f_max_unpool.sv
// Float max-unpool: latches a pooled value and its argmax per window
// and emits it at that position, +0.0 elsewhere. Macro: F_MAX_UNPOOL_IDX_CLAMP_EN.
module f_max_unpool
  import f_max_unpool_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DELAY_W = DELAY_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               running,
  input  logic [DELAY_W-1:0] strideMinusOne,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [DATA_W-1:0]  in0,
  input  logic [DELAY_W-1:0] in1,
  output logic [DATA_W-1:0]  out0
);

  localparam logic [DATA_W-1:0] ZF = DATA_W'(F_ZERO);

  logic               start;
  logic [DELAY_W-1:0] idx_in;
  logic [DATA_W-1:0]  val;
  logic [DELAY_W-1:0] idx;
  logic [DELAY_W-1:0] pos;
  logic               valid;
  logic [DATA_W-1:0]  out;

  f_unpool_phase #(
    .DELAY_W(DELAY_W)
  ) u_phase (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .strideMinusOne(strideMinusOne),
    .delay0        (delay0),
    .start         (start)
  );

`ifdef F_MAX_UNPOOL_IDX_CLAMP_EN
  // Out-of-range argmax lands on the last window position.
  always_comb begin
    idx_in = in1;
    if (in1 > strideMinusOne)
      idx_in = strideMinusOne;
  end
`else
  // Out-of-range argmax simply never matches a position.
  always_comb begin
    idx_in = in1;
  end
`endif

  // Window latch, position walk and registered zero-fill select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val   <= '0;
      idx   <= '0;
      pos   <= '0;
      valid <= 1'b0;
      out   <= '0;
    end else if (run) begin
      valid <= 1'b0;
      if (running)
        out <= ZF;
    end else if (running) begin
      if (start) begin
        val   <= in0;
        idx   <= idx_in;
        pos   <= DELAY_W'(1);
        valid <= 1'b1;
        out   <= (idx_in == '0) ? in0 : ZF;
      end else if (valid) begin
        out <= (pos == idx) ? val : ZF;
        pos <= pos + DELAY_W'(1);
      end else begin
        out <= ZF;
      end
    end
  end

  assign out0 = out;

endmodule

// File: tb/tb_f_max_unpool.sv
// Directed bench for f_max_unpool.
// Hand-computed out0 sequences per test scenario.
module tb_f_max_unpool;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        running = 1'b0;
  logic [6:0]  strideMinusOne = '0;
  logic [6:0]  delay0 = '0;
  logic [31:0] in0 = '0;
  logic [6:0]  in1 = '0;
  logic [31:0] out0;

  int checks = 0;
  int failures = 0;

  f_max_unpool dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .running       (running),
    .strideMinusOne(strideMinusOne),
    .delay0        (delay0),
    .in0           (in0),
    .in1           (in1),
    .out0          (out0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] exp);
    checks++;
    assert (out0 === exp) else begin
      failures++;
      $error("FAIL %s out0=%h expected=%h", tag, out0, exp);
    end
  endtask

  // Drive inputs for one cycle, clock, then check out0 after the edge.
  task automatic step(input logic r, input logic en,
                      input logic [31:0] v, input logic [6:0] i,
                      input string tag, input logic [31:0] exp);
    run = r;
    running = en;
    in0 = v;
    in1 = i;
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    #2;
    chk("reset", 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 32'h0, 0, "idle0", 32'h0);
    step(0, 0, 32'h12345678, 0, "idle1", 32'h0);
    step(0, 0, 32'h0, 0, "idle2", 32'h0);

    strideMinusOne = 7'd3;
    delay0 = 7'd2;
    step(1, 1, 32'h0, 0, "bw_run", 32'h0);
    step(0, 1, 32'h0, 0, "bw_1", 32'h0);
    step(0, 1, 32'h0, 0, "bw_2", 32'h0);
    step(0, 1, 32'h40400000, 2, "bw_3", 32'h0);
    step(0, 1, 32'h0, 0, "bw_4", 32'h0);
    step(0, 1, 32'h0, 0, "bw_5", 32'h40400000);
    step(0, 1, 32'h0, 0, "bw_6", 32'h0);

    strideMinusOne = 7'd1;
    delay0 = 7'd0;
    step(1, 1, 32'h0, 0, "b2b_run", 32'h0);
    step(0, 1, 32'hBF800000, 0, "b2b_1", 32'hBF800000);
    step(0, 1, 32'h0, 0, "b2b_2", 32'h0);
    step(0, 1, 32'h3F800000, 1, "b2b_3", 32'h0);
    step(0, 1, 32'h0, 0, "b2b_4", 32'h3F800000);

    strideMinusOne = 7'd2;
    step(1, 1, 32'h0, 0, "oor_run", 32'h0);
    step(0, 1, 32'h41200000, 5, "oor_1", 32'h0);
    step(0, 1, 32'h0, 0, "oor_2", 32'h0);
`ifdef F_MAX_UNPOOL_IDX_CLAMP_EN
    step(0, 1, 32'h0, 0, "oor_3", 32'h41200000);
`else
    step(0, 1, 32'h0, 0, "oor_3", 32'h0);
`endif

    strideMinusOne = 7'd7;
    step(1, 1, 32'h0, 0, "st_run", 32'h0);
    step(0, 1, 32'h40A00000, 2, "st_p0", 32'h0);
    step(0, 1, 32'h0, 0, "st_p1", 32'h0);
    step(0, 0, 32'h0, 0, "st_hold1", 32'h0);
    step(0, 0, 32'h0, 0, "st_hold2", 32'h0);
    step(0, 0, 32'h0, 0, "st_hold3", 32'h0);
    step(0, 1, 32'h0, 0, "st_p2", 32'h40A00000);
    step(0, 1, 32'h0, 0, "st_p3", 32'h0);
    step(0, 1, 32'h0, 0, "st_p4", 32'h0);

    strideMinusOne = 7'd3;
    step(1, 1, 32'h0, 0, "rm_run", 32'h0);
    step(0, 1, 32'h40E00000, 2, "rm_p0", 32'h0);
    step(0, 1, 32'h0, 0, "rm_p1", 32'h0);
    delay0 = 7'd1;
    step(1, 1, 32'h0, 0, "rm_abort", 32'h0);
    step(0, 1, 32'h0, 0, "rm_wait", 32'h0);
    step(0, 1, 32'h41000000, 1, "rm_q0", 32'h0);
    step(0, 1, 32'h0, 0, "rm_q1", 32'h41000000);

    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 32'h0);
    #1;
    rst = 1'b0;
    step(0, 0, 32'h0, 0, "post_rst", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
